// File: rtl/pipe_control.sv
// Pipelined control decoder: decodes ID into the ID/EX control bundle and owns the
// load-use, multi-cycle MUL and redirect-flush interlocks for the front of the pipe.
module pipe_control #(
  parameter int RA_W    = 3,
  parameter int ALUOP_W = 3,
  parameter int MUL_LAT = 3,
  parameter bit R0_HARD = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [3:0]         id_inst,
  input  logic [RA_W-1:0]    id_rs,
  input  logic [RA_W-1:0]    id_rt,
  input  logic [RA_W-1:0]    id_rd,
  input  logic               ex_redirect,
  output logic               ex_valid,
  output logic [9:0]         ex_ctrl,
  output logic [ALUOP_W-1:0] ex_aluop,
  output logic [RA_W-1:0]    ex_rd,
  output logic               stall,
  output logic               mul_busy,
  output logic               illegal
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_COM  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_MUL  = 4'b0111;
  localparam logic [3:0] OP_LW   = 4'b1000;
  localparam logic [3:0] OP_SW   = 4'b1001;
  localparam logic [3:0] OP_BEQ  = 4'b1010;
  localparam logic [3:0] OP_JUMP = 4'b1100;
  localparam logic [3:0] OP_JAL  = 4'b1101;
  localparam logic [3:0] OP_JR   = 4'b1110;

  // Control bundle bit positions: {wen,alusrc,regDst,memWrite,memRead,memToReg,branch,jump,jal,jr}
  localparam int B_WEN   = 9;
  localparam int B_ASRC  = 8;
  localparam int B_RDST  = 7;
  localparam int B_MWR   = 6;
  localparam int B_MRD   = 5;
  localparam int B_M2R   = 4;
  localparam int B_BR    = 3;
  localparam int B_JMP   = 2;
  localparam int B_JAL   = 1;
  localparam int B_JR    = 0;

  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((MUL_LAT > 1) ? MUL_LAT - 1 : 0);

  // ST_RUN  | normal issue, ID may advance into EX
  // ST_MULW | MUL held in EX for its remaining latency cycles
  typedef enum logic {ST_RUN = 1'b0, ST_MULW = 1'b1} state_t;

  state_t             r_state, w_nxt_state;
  logic [CNT_W-1:0]   r_cnt, w_nxt_cnt;
  logic               r_ex_valid, w_nxt_ex_valid;
  logic [9:0]         r_ex_ctrl, w_nxt_ex_ctrl;
  logic [ALUOP_W-1:0] r_ex_aluop, w_nxt_ex_aluop;
  logic [RA_W-1:0]    r_ex_rd, w_nxt_ex_rd;
  logic               r_illegal, w_nxt_illegal;

  logic [9:0]         w_dec_ctrl;
  logic [ALUOP_W-1:0] w_dec_aluop;
  logic               w_dec_legal;
  logic               w_reads_rs;
  logic               w_reads_rt;
  logic               w_rd_hazard_ok;
  logic               w_lu;
  logic               w_mulw;

  always_comb begin
    w_dec_ctrl  = '0;
    w_dec_aluop = '0;
    w_dec_legal = 1'b1;
    w_reads_rs  = 1'b1;
    w_reads_rt  = 1'b0;
    unique case (id_inst)
      OP_ADD, OP_SUB, OP_AND, OP_XOR, OP_COM, OP_MUL: begin
        w_dec_ctrl[B_WEN] = 1'b1;
        w_dec_ctrl[B_M2R] = 1'b1;
        w_dec_aluop       = id_inst[ALUOP_W-1:0];
        w_reads_rt        = 1'b1;
      end
      OP_SLL, OP_SRL: begin
        w_dec_ctrl[B_WEN]  = 1'b1;
        w_dec_ctrl[B_M2R]  = 1'b1;
        w_dec_ctrl[B_ASRC] = 1'b1;
        w_dec_aluop        = id_inst[ALUOP_W-1:0];
      end
      OP_LW: begin
        w_dec_ctrl[B_WEN]  = 1'b1;
        w_dec_ctrl[B_ASRC] = 1'b1;
        w_dec_ctrl[B_MRD]  = 1'b1;
      end
      OP_SW: begin
        w_dec_ctrl[B_ASRC] = 1'b1;
        w_dec_ctrl[B_RDST] = 1'b1;
        w_dec_ctrl[B_MWR]  = 1'b1;
        w_reads_rt         = 1'b1;
      end
      OP_BEQ: begin
        w_dec_ctrl[B_RDST] = 1'b1;
        w_dec_ctrl[B_BR]   = 1'b1;
        w_dec_aluop        = id_inst[ALUOP_W-1:0];
        w_reads_rt         = 1'b1;
      end
      OP_JUMP: begin
        w_dec_ctrl[B_JMP] = 1'b1;
        w_reads_rs        = 1'b0;
      end
      OP_JAL: begin
        w_dec_ctrl[B_WEN] = 1'b1;
        w_dec_ctrl[B_JMP] = 1'b1;
        w_dec_ctrl[B_JAL] = 1'b1;
        w_reads_rs        = 1'b0;
      end
      OP_JR: begin
        w_dec_ctrl[B_JR] = 1'b1;
      end
      default: begin
        w_dec_legal = 1'b0;
      end
    endcase
  end

  // A load targeting hardwired r0 never produces a value anyone waits on.
  assign w_rd_hazard_ok = !(R0_HARD && (r_ex_rd == '0));
  assign w_lu = r_ex_valid && r_ex_ctrl[B_MRD] && id_valid && w_rd_hazard_ok &&
                ((w_reads_rs && (id_rs == r_ex_rd)) || (w_reads_rt && (id_rt == r_ex_rd)));

  assign w_mulw   = (r_state == ST_MULW);
  assign stall    = !ex_redirect && (w_mulw || w_lu);
  assign mul_busy = w_mulw;

  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_cnt      = r_cnt;
    w_nxt_ex_valid = r_ex_valid;
    w_nxt_ex_ctrl  = r_ex_ctrl;
    w_nxt_ex_aluop = r_ex_aluop;
    w_nxt_ex_rd    = r_ex_rd;
    w_nxt_illegal  = 1'b0;
    if (ex_redirect) begin
      w_nxt_state    = ST_RUN;
      w_nxt_cnt      = '0;
      w_nxt_ex_valid = 1'b0;
      w_nxt_ex_ctrl  = '0;
      w_nxt_ex_aluop = '0;
      w_nxt_ex_rd    = '0;
    end else if (w_mulw) begin
      w_nxt_cnt = r_cnt - 1'b1;
      if (r_cnt == CNT_W'(1)) begin
        w_nxt_state = ST_RUN;
      end
    end else if (w_lu || !id_valid || !w_dec_legal) begin
      w_nxt_ex_valid = 1'b0;
      w_nxt_ex_ctrl  = '0;
      w_nxt_ex_aluop = '0;
      w_nxt_ex_rd    = '0;
      w_nxt_illegal  = !w_lu && id_valid && !w_dec_legal;
    end else begin
      w_nxt_ex_valid = 1'b1;
      w_nxt_ex_ctrl  = w_dec_ctrl;
      w_nxt_ex_aluop = w_dec_aluop;
      w_nxt_ex_rd    = id_rd;
      if ((id_inst == OP_MUL) && (MUL_LAT > 1)) begin
        w_nxt_state = ST_MULW;
        w_nxt_cnt   = CNT_LOAD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_RUN;
      r_cnt      <= '0;
      r_ex_valid <= 1'b0;
      r_ex_ctrl  <= '0;
      r_ex_aluop <= '0;
      r_ex_rd    <= '0;
      r_illegal  <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_cnt      <= w_nxt_cnt;
      r_ex_valid <= w_nxt_ex_valid;
      r_ex_ctrl  <= w_nxt_ex_ctrl;
      r_ex_aluop <= w_nxt_ex_aluop;
      r_ex_rd    <= w_nxt_ex_rd;
      r_illegal  <= w_nxt_illegal;
    end
  end

  assign ex_valid = r_ex_valid;
  assign ex_ctrl  = r_ex_ctrl;
  assign ex_aluop = r_ex_aluop;
  assign ex_rd    = r_ex_rd;
  assign illegal  = r_illegal;

endmodule

// File: tb/tb_pipe_control.sv
// Bench for pipe_control: directed pipeline scenarios followed by random traffic, all scored
// against a cycle-level behavioural model through an expected-response queue.
module tb_pipe_control;

  localparam int MUL_LAT = 3;
  localparam bit R0_HARD = 1'b1;

  localparam logic [9:0] WEN  = 10'b1000000000;
  localparam logic [9:0] ASRC = 10'b0100000000;
  localparam logic [9:0] RDST = 10'b0010000000;
  localparam logic [9:0] MWR  = 10'b0001000000;
  localparam logic [9:0] MRD  = 10'b0000100000;
  localparam logic [9:0] M2R  = 10'b0000010000;
  localparam logic [9:0] BR   = 10'b0000001000;
  localparam logic [9:0] JMP  = 10'b0000000100;
  localparam logic [9:0] JAL  = 10'b0000000010;
  localparam logic [9:0] JR   = 10'b0000000001;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid = 1'b0;
  logic [3:0] id_inst = 4'd0;
  logic [2:0] id_rs = 3'd0, id_rt = 3'd0, id_rd = 3'd0;
  logic       ex_redirect = 1'b0;
  logic       ex_valid;
  logic [9:0] ex_ctrl;
  logic [2:0] ex_aluop;
  logic [2:0] ex_rd;
  logic       stall, mul_busy, illegal;

  pipe_control #(.RA_W(3), .ALUOP_W(3), .MUL_LAT(MUL_LAT), .R0_HARD(R0_HARD)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_inst(id_inst), .id_rs(id_rs),
    .id_rt(id_rt), .id_rd(id_rd), .ex_redirect(ex_redirect), .ex_valid(ex_valid),
    .ex_ctrl(ex_ctrl), .ex_aluop(ex_aluop), .ex_rd(ex_rd), .stall(stall),
    .mul_busy(mul_busy), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ev;
    logic [9:0] ctrl;
    logic [2:0] aluop;
    logic [2:0] rd;
    logic       stall;
    logic       busy;
    logic       ill;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  // Model state: what EX holds and how many more cycles a MUL keeps it.
  bit         m_init = 0;
  logic       m_ev;
  logic [9:0] m_ctrl;
  logic [2:0] m_aluop;
  logic [2:0] m_rd;
  int         m_hold;
  logic       m_ill;
  logic       last_stall = 1'b0;

  function automatic logic [9:0] ctrl_of(logic [3:0] op);
    case (op)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd7: return WEN | M2R;
      4'd5, 4'd6: return WEN | M2R | ASRC;
      4'd8:  return WEN | ASRC | MRD;
      4'd9:  return ASRC | RDST | MWR;
      4'd10: return RDST | BR;
      4'd12: return JMP;
      4'd13: return WEN | JMP | JAL;
      4'd14: return JR;
      default: return 10'd0;
    endcase
  endfunction

  function automatic bit legal(logic [3:0] op);
    return (op != 4'd11) && (op != 4'd15);
  endfunction

  function automatic bit reads_rt(logic [3:0] op);
    return op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd9, 4'd10};
  endfunction

  function automatic bit reads_rs(logic [3:0] op);
    return (op != 4'd12) && (op != 4'd13);
  endfunction

  function automatic bit load_use();
    bit dep;
    if (!(m_ev && (m_ctrl & MRD) != 10'd0 && id_valid)) return 1'b0;
    if (R0_HARD && m_rd == 3'd0) return 1'b0;
    dep = (reads_rs(id_inst) && id_rs == m_rd) || (reads_rt(id_inst) && id_rt == m_rd);
    return dep;
  endfunction

  task automatic bubble();
    m_ev = 1'b0; m_ctrl = '0; m_aluop = '0; m_rd = '0;
  endtask

  task automatic model_step();
    bit lu;
    if (rst) begin
      m_init = 1; bubble(); m_hold = 0; m_ill = 1'b0;
    end else if (m_init) begin
      lu    = load_use();
      m_ill = 1'b0;
      if (ex_redirect) begin
        bubble(); m_hold = 0;
      end else if (m_hold > 0) begin
        m_hold--;
      end else if (lu) begin
        bubble();
      end else if (id_valid && legal(id_inst)) begin
        m_ev    = 1'b1;
        m_ctrl  = ctrl_of(id_inst);
        m_aluop = (id_inst <= 4'd7 || id_inst == 4'd10) ? id_inst[2:0] : 3'd0;
        m_rd    = id_rd;
        m_hold  = (id_inst == 4'd7) ? MUL_LAT - 1 : 0;
      end else begin
        bubble();
        m_ill = id_valid;
      end
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [3:0] op,
                       input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] rd,
                       input logic redir);
    exp_t e;
    @(posedge clk);
    model_step();
    #1;
    rst = r; id_valid = v; id_inst = op; id_rs = rs; id_rt = rt; id_rd = rd;
    ex_redirect = redir;
    if (m_init) begin
      e.ev = m_ev; e.ctrl = m_ctrl; e.aluop = m_aluop; e.rd = m_rd; e.ill = m_ill;
      e.busy  = (m_hold > 0);
      e.stall = !redir && ((m_hold > 0) || load_use());
      last_stall = e.stall;
      q.push_back(e);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("ex_valid", 32'(ex_valid), 32'(e.ev));
        chk("ex_ctrl", 32'(ex_ctrl), 32'(e.ctrl));
        chk("ex_aluop", 32'(ex_aluop), 32'(e.aluop));
        chk("ex_rd", 32'(ex_rd), 32'(e.rd));
        chk("stall", 32'(stall), 32'(e.stall));
        chk("mul_busy", 32'(mul_busy), 32'(e.busy));
        chk("illegal", 32'(illegal), 32'(e.ill));
      end
    end
  end

  initial begin : stimulus
    logic [3:0] op;
    logic [2:0] rs, rt, rd;
    logic       v, redir, r;
    // reset, then ADD r1,r2->r3
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 4'd0, 3'd1, 3'd2, 3'd3, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    // load-use on r2, ADD held in ID for the stall cycle
    drive(0, 1, 4'd8, 3'd1, 3'd0, 3'd2, 0);
    drive(0, 1, 4'd0, 3'd2, 3'd3, 3'd4, 0);
    drive(0, 1, 4'd0, 3'd2, 3'd3, 3'd4, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    // MUL hold with a SUB waiting behind it
    drive(0, 1, 4'd7, 3'd1, 3'd2, 3'd5, 0);
    for (int i = 0; i < MUL_LAT; i++) drive(0, 1, 4'd1, 3'd3, 3'd4, 3'd6, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    // BEQ resolved taken, SUB in ID is flushed
    drive(0, 1, 4'd10, 3'd1, 3'd2, 3'd0, 0);
    drive(0, 1, 4'd1, 3'd3, 3'd4, 3'd5, 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    // undefined opcodes
    drive(0, 1, 4'd11, 3'd1, 3'd2, 3'd3, 0);
    drive(0, 1, 4'd15, 3'd1, 3'd2, 3'd3, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    // load to r0 never interlocks
    drive(0, 1, 4'd8, 3'd1, 3'd0, 3'd0, 0);
    drive(0, 1, 4'd0, 3'd0, 3'd0, 3'd1, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    // reset during the MUL hold
    drive(0, 1, 4'd7, 3'd1, 3'd2, 3'd3, 0);
    drive(1, 1, 4'd0, 3'd1, 3'd2, 3'd3, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    // random traffic; ID contents are held while the pipe reports a stall
    for (int n = 0; n < 2000; n++) begin
      if (!last_stall) begin
        v  = ($urandom_range(0, 9) != 0);
        case ($urandom_range(0, 5))
          0: op = 4'd8;
          1: op = 4'd7;
          default: op = 4'($urandom_range(0, 15));
        endcase
        rs = 3'($urandom_range(0, 3));
        rt = 3'($urandom_range(0, 3));
        rd = 3'($urandom_range(0, 3));
      end
      redir = ($urandom_range(0, 11) == 0);
      r     = ($urandom_range(0, 99) == 0);
      drive(r, v, op, rs, rt, rd, redir);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
